// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge block.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'd0,
        CONFIRM_HIGH = 2'd1,
        IDLE_HIGH    = 2'd2,
        CONFIRM_LOW  = 2'd3
    } state_t;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/debounce_edge_if.sv
// Level-in / debounced-level-and-pulses-out bundle for debounce_edge.
interface debounce_edge_if;

    logic       sync_in;
    logic       clear;
    logic       stable_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    modport master (
        output sync_in, clear,
        input  stable_out, rise_pulse, fall_pulse, glitch_count
    );

    modport slave (
        input  sync_in, clear,
        output stable_out, rise_pulse, fall_pulse, glitch_count
    );

endinterface

// File: rtl/dbnc_counter.sv
// Up-counter with synchronous clear, count enable and terminal-value compare.
module dbnc_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_count_enable,
    input  logic [WIDTH-1:0] i_term_val,
    output logic             o_at_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)              r_count <= '0;
        else if (i_clear)        r_count <= '0;
        else if (i_count_enable) r_count <= r_count + 1'b1;
    end

    assign o_at_term = (r_count == i_term_val);

endmodule

// File: rtl/debounce_edge.sv
// Debounces a synchronized level: a new level must persist STABLE_CYCLES
// samples before it is accepted; rejected transitions are counted.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_WIDTH     = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic            clk,
    input  logic            n_rst,
    debounce_edge_if.slave  bus
);

    localparam state_t                RESET_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;
    localparam logic [CNT_WIDTH-1:0]  TERM_VAL    = CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_at_term;
    logic       w_rise;
    logic       w_fall;
    logic       w_glitch;
    logic       r_stable;
    logic       r_rise;
    logic       r_fall;
    logic [7:0] r_glitch;

    dbnc_counter #(.WIDTH(CNT_WIDTH)) u_confirm_cnt (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_clear        (w_cnt_clr),
        .i_count_enable (w_cnt_en),
        .i_term_val     (TERM_VAL),
        .o_at_term      (w_at_term)
    );

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_glitch     = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (bus.sync_in) begin
                    w_next_state = CONFIRM_HIGH;
                    w_cnt_en     = 1'b1;
                end
            end
            CONFIRM_HIGH: begin
                if (!bus.sync_in) begin
                    w_next_state = IDLE_LOW;
                    w_cnt_clr    = 1'b1;
                    w_glitch     = 1'b1;
                end else if (w_at_term) begin
                    w_next_state = IDLE_HIGH;
                    w_cnt_clr    = 1'b1;
                    w_rise       = 1'b1;
                end else begin
                    w_cnt_en     = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!bus.sync_in) begin
                    w_next_state = CONFIRM_LOW;
                    w_cnt_en     = 1'b1;
                end
            end
            CONFIRM_LOW: begin
                if (bus.sync_in) begin
                    w_next_state = IDLE_HIGH;
                    w_cnt_clr    = 1'b1;
                    w_glitch     = 1'b1;
                end else if (w_at_term) begin
                    w_next_state = IDLE_LOW;
                    w_cnt_clr    = 1'b1;
                    w_fall       = 1'b1;
                end else begin
                    w_cnt_en     = 1'b1;
                end
            end
            default: begin
                w_next_state = r_stable ? IDLE_HIGH : IDLE_LOW;
                w_cnt_clr    = 1'b1;
            end
        endcase
        // Clear wins: a transition that would be accepted this cycle is dropped.
        if (bus.clear) begin
            w_next_state = r_stable ? IDLE_HIGH : IDLE_LOW;
            w_cnt_clr    = 1'b1;
            w_cnt_en     = 1'b0;
            w_rise       = 1'b0;
            w_fall       = 1'b0;
            w_glitch     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= RESET_STATE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stable <= RESET_LEVEL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 8'd0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
            if (w_rise)      r_stable <= 1'b1;
            else if (w_fall) r_stable <= 1'b0;
            if (bus.clear)                               r_glitch <= 8'd0;
            else if (w_glitch && r_glitch != GLITCH_MAX) r_glitch <= r_glitch + 8'd1;
        end
    end

    assign bus.stable_out   = r_stable;
    assign bus.rise_pulse   = r_rise;
    assign bus.fall_pulse   = r_fall;
    assign bus.glitch_count = r_glitch;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed checks of debounce_edge with STABLE_CYCLES=4.
module tb_debounce_edge;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    debounce_edge_if bus();

    debounce_edge #(
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (4),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic r, input logic f,
                           input logic [7:0] g);
        chk({tag, ".stable"}, {7'd0, bus.stable_out}, {7'd0, s});
        chk({tag, ".rise"},   {7'd0, bus.rise_pulse}, {7'd0, r});
        chk({tag, ".fall"},   {7'd0, bus.fall_pulse}, {7'd0, f});
        chk({tag, ".glitch"}, bus.glitch_count, g);
    endtask

    // Drive the level at a negedge, then sample just after the next posedge.
    task automatic step(input logic v);
        @(negedge clk);
        bus.sync_in = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] eg;
        bus.sync_in = 1'b0;
        bus.clear   = 1'b0;

        // power-on reset
        #2 n_rst = 1'b0;
        #1 chk_out("por_imm", 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1 chk_out("por_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk) n_rst = 1'b1;

        // clean rise
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk_out("rise_wait", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        step(1'b1); chk_out("rise_accept", 1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1); chk_out("rise_after",  1'b1, 1'b0, 1'b0, 8'd0);

        // 3-cycle low glitch
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk_out("glitch_low", 1'b1, 1'b0, 1'b0, 8'd0);
        end
        step(1'b1); chk_out("glitch_end",  1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b1); chk_out("glitch_hold", 1'b1, 1'b0, 1'b0, 8'd1);

        // clear on the accepting cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk_out("clr_wait", 1'b1, 1'b0, 1'b0, 8'd1);
        end
        @(negedge clk);
        bus.sync_in = 1'b0;
        bus.clear   = 1'b1;
        @(posedge clk);
        #1 chk_out("clr_prio", 1'b1, 1'b0, 1'b0, 8'd0);
        bus.clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk_out("clr_reconfirm", 1'b1, 1'b0, 1'b0, 8'd0);
        end
        step(1'b0); chk_out("clr_fall",  1'b0, 1'b0, 1'b1, 8'd0);
        step(1'b0); chk_out("clr_after", 1'b0, 1'b0, 1'b0, 8'd0);

        // back to stable 1
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk_out("rerise_wait", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        step(1'b1); chk_out("rerise_accept", 1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1); chk_out("rerise_after",  1'b1, 1'b0, 1'b0, 8'd0);

        // saturation: 300 two-cycle low glitches
        for (int g = 1; g <= 300; g++) begin
            eg = (g > 255) ? 8'd255 : 8'(g);
            step(1'b0); chk_out("sat_low1", 1'b1, 1'b0, 1'b0, 8'(g - 1 > 255 ? 255 : g - 1));
            step(1'b0); chk_out("sat_low2", 1'b1, 1'b0, 1'b0, 8'(g - 1 > 255 ? 255 : g - 1));
            step(1'b1); chk_out("sat_high", 1'b1, 1'b0, 1'b0, eg);
        end
        chk("sat_final", bus.glitch_count, 8'd255);

        // reset mid-confirm
        step(1'b0); chk_out("rst_conf1", 1'b1, 1'b0, 1'b0, 8'd255);
        step(1'b0); chk_out("rst_conf2", 1'b1, 1'b0, 1'b0, 8'd255);
        #2 n_rst = 1'b0;
        #1 chk_out("rst_abort", 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1 chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk) n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk_out("post_rst_wait", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        step(1'b1); chk_out("post_rst_rise", 1'b1, 1'b1, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
